text_buffer_16x16: RTL and testbench

Writable 16x16 character buffer that pairs with the read-only character ROM in the text overlay path. A byte stream (console or UART style) is accepted through a valid/ready port, interpreted with a small control-code set, and stored at a hardware cursor. The read port uses the same packed `char_xy` / `char_code` convention as the ROM, so the pixel-side character renderer can use this block as a drop-in replacement.

---
 rtl/text_buffer_16x16.sv | 123 ++++++++++++
 tb/tb_text_buffer_16x16.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_16x16.sv
// 16x16 writable character buffer with a byte-stream write port and a hardware cursor.
// Read port matches the character ROM convention (char_xy = {x, y}, one-cycle registered read).
module text_buffer_16x16 #(
    parameter logic [6:0] CLR_CHAR = 7'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_char,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic [7:0] cursor_xy,
    output logic       busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t     state_reg;
    logic [7:0] clr_cnt_reg;
    logic [3:0] cur_x_reg;
    logic [3:0] cur_y_reg;

    logic [6:0] mem [0:255];

    logic       accept;
    logic       is_print;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [6:0] mem_wdata;

    assign accept   = wr_valid && (state_reg == IDLE);
    assign is_print = (wr_char >= 8'h20) && (wr_char <= 8'h7E);

    assign wr_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == CLEAR);
    assign cursor_xy = {cur_x_reg, cur_y_reg};

    // Single write port shared by the clear sweep and printable characters.
    // Writes are held off while reset is asserted so the RAM keeps its contents.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_reg;
        mem_wdata = CLR_CHAR;
        if (state_reg == CLEAR) begin
            mem_we = rst_n;
        end else if (accept && is_print) begin
            mem_we    = rst_n;
            mem_waddr = {cur_y_reg, cur_x_reg};
            mem_wdata = wr_char[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-before-write falls out of the non-blocking update of mem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code <= 7'h00;
        end else begin
            char_code <= mem[{char_xy[3:0], char_xy[7:4]}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= 8'd0;
            cur_x_reg   <= 4'd0;
            cur_y_reg   <= 4'd0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 8'd1;
                    cur_x_reg   <= 4'd0;
                    cur_y_reg   <= 4'd0;
                    if (clr_cnt_reg == 8'hFF) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            // 4-bit fields wrap naturally at column 15 and row 15.
                            cur_x_reg <= cur_x_reg + 4'd1;
                            if (cur_x_reg == 4'hF) begin
                                cur_y_reg <= cur_y_reg + 4'd1;
                            end
                        end else if (wr_char == 8'h0D) begin
                            cur_x_reg <= 4'd0;
                        end else if (wr_char == 8'h0A) begin
                            cur_x_reg <= 4'd0;
                            cur_y_reg <= cur_y_reg + 4'd1;
                        end else if (wr_char == 8'h08) begin
                            if (cur_x_reg != 4'd0) begin
                                cur_x_reg <= cur_x_reg - 4'd1;
                            end else if (cur_y_reg != 4'd0) begin
                                cur_x_reg <= 4'hF;
                                cur_y_reg <= cur_y_reg - 4'd1;
                            end
                        end else if (wr_char == 8'h0C) begin
                            state_reg   <= CLEAR;
                            clr_cnt_reg <= 8'd0;
                            cur_x_reg   <= 4'd0;
                            cur_y_reg   <= 4'd0;
                        end
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer_16x16.sv
// Directed plus randomized bench for text_buffer_16x16 against a cell-array console model.
module tb_text_buffer_16x16;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_char;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic [7:0] cursor_xy;
    logic       busy;

    int tests_run;
    int tests_failed;

    // Reference model: screen as a flat array of cells plus a cursor (column, row).
    logic [6:0] model_mem [256];
    int         mx;
    int         my;

    text_buffer_16x16 #(.CLR_CHAR(7'h20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_char   (wr_char),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .char_xy   (char_xy),
        .char_code (char_code),
        .cursor_xy (cursor_xy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 7'h20;
        mx = 0;
        my = 0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        int idx;
        idx = my * 16 + mx;
        if (b >= 8'h20 && b <= 8'h7E) begin
            model_mem[idx] = b[6:0];
            idx = (idx + 1) % 256;
            mx  = idx % 16;
            my  = idx / 16;
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            mx = 0;
            my = (my + 1) % 16;
        end else if (b == 8'h08) begin
            if (idx > 0) idx = idx - 1;
            mx = idx % 16;
            my = idx / 16;
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endtask

    function automatic logic [7:0] model_cursor();
        return 8'(mx * 16 + my);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        wr_char  = b;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        wr_char  = 8'($urandom);
        model_apply(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    endtask

    task automatic wait_ready(input int expected_edges, input string tag);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check(tag, n, expected_edges);
    endtask

    task automatic read_cell(input int x, input int y, input logic [6:0] expected, input string tag);
        char_xy = 8'(x * 16 + y);
        step();
        check(tag, char_code, expected);
    endtask

    task automatic full_readback(input string tag);
        for (int i = 0; i < 256; i++) begin
            char_xy = 8'((i % 16) * 16 + (i / 16));
            step();
            check($sformatf("%s[%0d]", tag, i), char_code, model_mem[i]);
        end
    endtask

    initial begin
        logic [7:0] others [7];
        int         n;
        int         r;
        logic [7:0] b;

        others = '{8'h00, 8'h07, 8'h1B, 8'h7F, 8'h8C, 8'hC1, 8'hFF};
        tests_run    = 0;
        tests_failed = 0;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        char_xy  = 8'h00;
        rst_n    = 1'b1;
        model_clear();

        // 1. Reset clear
        #2 rst_n = 1'b0;
        #1;
        check("reset_char_code", char_code, 7'h00);
        check("reset_ready", wr_ready, 1'b0);
        check("reset_busy", busy, 1'b1);
        check("reset_cursor", cursor_xy, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        wait_ready(256, "reset_clear_len");
        check("reset_busy_done", busy, 1'b0);
        check("reset_cursor_done", cursor_xy, 8'h00);
        full_readback("reset_fill");

        // 2. Print and wrap
        for (int i = 0; i < 17; i++) send_byte(8'h41);
        check("wrap_cursor", cursor_xy, 8'h11);
        read_cell(0, 1, 7'h41, "wrap_cell_0_1");
        read_cell(15, 0, 7'h41, "wrap_cell_15_0");
        read_cell(1, 1, 7'h20, "wrap_cell_1_1");
        full_readback("wrap");

        // 3. Controls (start from a freshly cleared screen)
        send_byte(8'h0C);
        check("ff_ready_low", wr_ready, 1'b0);
        wait_ready(256, "ff_clear_len");
        send_str("AB");
        send_byte(8'h0D);
        send_str("C");
        read_cell(0, 0, 7'h43, "ctrl_cell_0_0");
        read_cell(1, 0, 7'h42, "ctrl_cell_1_0");
        send_byte(8'h0A);
        check("lf_cursor", cursor_xy, model_cursor());
        send_byte(8'h08);
        check("bs_cursor", cursor_xy, 8'hF0);

        // 4. Corner wrap
        send_byte(8'h0D);
        for (int i = 0; i < 256; i++) send_byte(8'h5A);
        check("fill_cursor", cursor_xy, 8'h00);
        full_readback("fill_z");
        for (int i = 0; i < 15; i++) send_byte(8'h0A);
        check("lf_to_row15", cursor_xy, 8'h0F);
        send_byte(8'h0A);
        check("lf_row15_wrap", cursor_xy, 8'h00);
        send_byte(8'h08);
        check("bs_at_origin", cursor_xy, 8'h00);

        // 5. FF mid-stream with wr_valid held high
        wr_valid = 1'b1;
        wr_char  = 8'h51;
        step();
        model_apply(8'h51);
        wr_char = 8'h0C;
        step();
        model_apply(8'h0C);
        wr_char = 8'h52;
        n = 0;
        while (wr_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("held_valid_clear_len", n, 256);
        check("held_valid_cursor", cursor_xy, 8'h00);
        step();
        wr_valid = 1'b0;
        model_apply(8'h52);
        check("held_valid_r_cursor", cursor_xy, 8'h10);
        full_readback("ff_stream");

        // Randomized byte stream with idle gaps; cursor checked after every byte.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_char = 8'($urandom);
                step();
            end
            r = int'($urandom_range(0, 9));
            if (r <= 5)      b = 8'($urandom_range(32, 126));
            else if (r == 6) b = 8'h0D;
            else if (r == 7) b = 8'h0A;
            else if (r == 8) b = 8'h08;
            else             b = others[$urandom_range(0, 6)];
            send_byte(b);
            check($sformatf("rand_cursor_%0d_byte_%0h", k, b), cursor_xy, model_cursor());
        end
        full_readback("rand");

        // 6. Collision and latency
        send_byte(8'h0C);
        wait_ready(256, "ff2_clear_len");
        send_byte(8'h0A);
        send_byte(8'h0A);
        send_str("abc");
        check("coll_cursor", cursor_xy, 8'h32);
        char_xy = 8'h32;
        send_byte(8'h58);
        check("coll_old_data", char_code, 7'h20);
        step();
        check("coll_new_data", char_code, 7'h58);

        // Reset during a clear restarts the full sweep.
        send_byte(8'h0C);
        repeat (100) step();
        check("midclear_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midclear_rst_code", char_code, 7'h00);
        check("midclear_rst_cursor", cursor_xy, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        model_clear();
        wait_ready(256, "midclear_restart_len");

        // Reset mid-stream: address 0 is the first cell rewritten.
        send_byte(8'h4D);
        char_xy = 8'h00;
        rst_n = 1'b0;
        #1;
        check("midstream_rst_code", char_code, 7'h00);
        #1 rst_n = 1'b1;
        step();
        check("restart_read_old", char_code, 7'h4D);
        step();
        check("restart_addr0_cleared", char_code, 7'h20);
        model_clear();
        wait_ready(254, "restart_remaining_len");
        full_readback("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
